// File: rtl/exp2_block_avg.sv
// Block averager for a raster pixel stream: averages each run of 2^shift valid pixels
// within a line and discards partial blocks at blanking.
module exp2_block_avg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic [3:0] i_shift_bit,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic [7:0] o_interval,
    output logic [7:0] o_avg,
    output logic       o_avg_valid,
    output logic       o_drop,
    output logic       o_cfg_err
);

    logic [3:0]  shift_q, shift_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [14:0] acc_q, acc_d;
    logic [7:0]  avg_q, avg_d;
    logic        avg_valid_q, avg_valid_d;
    logic        drop_q, drop_d;

    logic        blank;
    logic        last_pixel;
    logic [14:0] sum;
    logic [14:0] sum_shifted;

    assign blank       = !i_hs || !i_vs;
    assign o_cfg_err   = shift_q[3];
    assign o_interval  = o_cfg_err ? 8'd0 : (8'd1 << shift_q[2:0]);
    assign last_pixel  = ({1'b0, cnt_q} == (o_interval - 8'd1));
    // acc never exceeds 127*255 before the final add, so 15 bits cannot overflow
    assign sum         = acc_q + {7'd0, i_data};
    assign sum_shifted = sum >> shift_q[2:0];

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        drop_d      = 1'b0;
        if (blank) begin
            // blanking wins over i_valid; cnt is cleared here so the drop pulse is single-cycle
            shift_d = i_shift_bit;
            cnt_d   = 7'd0;
            acc_d   = 15'd0;
            drop_d  = (cnt_q != 7'd0);
        end else if (!o_cfg_err && i_valid) begin
            if (last_pixel) begin
                avg_d       = sum_shifted[7:0];
                avg_valid_d = 1'b1;
                cnt_d       = 7'd0;
                acc_d       = 15'd0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= 4'd0;
            cnt_q       <= 7'd0;
            acc_q       <= 15'd0;
            avg_q       <= 8'd0;
            avg_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign o_avg       = avg_q;
    assign o_avg_valid = avg_valid_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_exp2_block_avg.sv
// Self-checking bench for exp2_block_avg: directed scenarios plus randomized lines,
// compared every cycle against a block-list averaging model.
module tb_exp2_block_avg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_hs = 1'b0;
    logic       i_vs = 1'b0;
    logic [3:0] i_shift_bit = 4'd0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic [7:0] o_interval;
    logic [7:0] o_avg;
    logic       o_avg_valid;
    logic       o_drop;
    logic       o_cfg_err;

    int errors = 0;
    int checks = 0;

    // model state: configured block exponent and the pixels gathered so far in this block
    int mShift;
    int mCount;
    int mSum;
    int expAvg;
    bit expValid;
    bit expDrop;

    int pulses;
    int drops;
    int lastAvg;

    always #5 clk = ~clk;

    exp2_block_avg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_hs        (i_hs),
        .i_vs        (i_vs),
        .i_shift_bit (i_shift_bit),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_interval  (o_interval),
        .o_avg       (o_avg),
        .o_avg_valid (o_avg_valid),
        .o_drop      (o_drop),
        .o_cfg_err   (o_cfg_err)
    );

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mShift   = 0;
        mCount   = 0;
        mSum     = 0;
        expAvg   = 0;
        expValid = 0;
        expDrop  = 0;
    endtask

    // one clock edge of the reference behaviour, using the inputs sampled at that edge
    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
            return;
        end
        expValid = 0;
        expDrop  = 0;
        if (!i_hs || !i_vs) begin
            if (mCount > 0) expDrop = 1;
            mCount = 0;
            mSum   = 0;
            mShift = int'(i_shift_bit);
        end else if (mShift < 8 && i_valid) begin
            mSum   += int'(i_data);
            mCount += 1;
            if (mCount == (1 << mShift)) begin
                expAvg   = mSum / mCount;
                expValid = 1;
                mSum     = 0;
                mCount   = 0;
            end
        end
    endtask

    task automatic checkOutput();
        int expInterval;
        expInterval = (mShift < 8) ? (1 << mShift) : 0;
        checkVal("interval", int'(o_interval), expInterval);
        checkVal("cfg_err", int'(o_cfg_err), (mShift >= 8) ? 1 : 0);
        checkVal("avg", int'(o_avg), expAvg);
        checkVal("avg_valid", int'(o_avg_valid), int'(expValid));
        checkVal("drop", int'(o_drop), int'(expDrop));
        checkVal("valid_drop_excl", int'(o_avg_valid & o_drop), 0);
        if (o_avg_valid) begin
            pulses++;
            lastAvg = int'(o_avg);
        end
        if (o_drop) drops++;
    endtask

    task automatic applyStimulus(input bit hs, input bit vs, input int shift,
                                 input bit valid, input int data);
        i_hs        = hs;
        i_vs        = vs;
        i_shift_bit = 4'(shift);
        i_valid     = valid;
        i_data      = 8'(data);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic clearCounts();
        pulses  = 0;
        drops   = 0;
        lastAvg = -1;
    endtask

    initial begin
        modelReset();
        clearCounts();

        // asynchronous reset with no clock edge involved
        #1 rst_n = 1'b0;
        #1;
        checkVal("rst_interval", int'(o_interval), 1);
        checkVal("rst_cfg_err", int'(o_cfg_err), 0);
        checkVal("rst_avg", int'(o_avg), 0);
        checkOutput();
        applyStimulus(1, 1, 3, 1, 99);
        applyStimulus(1, 1, 3, 1, 99);
        rst_n = 1'b1;

        // 10,20,30,40 in blocks of 4
        applyStimulus(0, 1, 2, 0, 0);
        applyStimulus(0, 1, 2, 0, 0);
        checkVal("req031_interval", int'(o_interval), 4);
        clearCounts();
        for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 2, 1, 10 * i);
        checkVal("req031_pulses", pulses, 1);
        checkVal("req031_avg", lastAvg, 25);
        applyStimulus(1, 1, 2, 0, 0);
        checkVal("req031_hold", int'(o_avg), 25);

        // 128 full-scale pixels with random gaps
        applyStimulus(0, 1, 7, 0, 0);
        clearCounts();
        for (int sent = 0; sent < 128;) begin
            bit v;
            v = ($urandom_range(0, 2) != 0);
            applyStimulus(1, 1, 7, v, v ? 255 : int'($urandom_range(0, 255)));
            if (v) sent++;
        end
        checkVal("req032_pulses", pulses, 1);
        checkVal("req032_avg", lastAvg, 255);

        // partial block dropped at horizontal blanking, valid ignored during blanking
        applyStimulus(1, 0, 3, 0, 0);
        clearCounts();
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 3, 1, 200);
        applyStimulus(0, 1, 3, 1, 7);
        applyStimulus(0, 1, 3, 1, 7);
        applyStimulus(0, 1, 3, 0, 0);
        checkVal("req033_drops", drops, 1);
        checkVal("req033_pulses", pulses, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 3, 1, 8 * i + 3);
        checkVal("req033_next_pulses", pulses, 1);
        checkVal("req033_next_avg", lastAvg, 31);

        // invalid configuration, then passthrough
        applyStimulus(0, 0, 9, 0, 0);
        checkVal("req034_cfg_err", int'(o_cfg_err), 1);
        checkVal("req034_interval", int'(o_interval), 0);
        clearCounts();
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 9, 1, 50 + i);
        applyStimulus(0, 1, 0, 0, 0);
        checkVal("req034_bad_pulses", pulses, 0);
        checkVal("req034_bad_drops", drops, 0);
        checkVal("req034_cfg_clear", int'(o_cfg_err), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 1, 17 * i + 1);
        checkVal("req034_pass_pulses", pulses, 5);
        checkVal("req034_pass_last", lastAvg, 69);

        // mid-line configuration change is deferred to the next blanking
        applyStimulus(0, 1, 2, 0, 0);
        clearCounts();
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, (i < 2) ? 2 : 5, 1, 4);
        checkVal("req035_pulses", pulses, 2);
        checkVal("req035_interval_hold", int'(o_interval), 4);
        applyStimulus(0, 1, 5, 0, 0);
        checkVal("req035_interval_next", int'(o_interval), 32);

        // reset in the middle of a block
        applyStimulus(0, 1, 2, 0, 0);
        clearCounts();
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 2, 1, 100);
        #2 rst_n = 1'b0;
        #1;
        checkVal("req036_rst_avg", int'(o_avg), 0);
        checkVal("req036_rst_valid", int'(o_avg_valid), 0);
        checkVal("req036_rst_drop", int'(o_drop), 0);
        checkVal("req036_rst_interval", int'(o_interval), 1);
        modelReset();
        applyStimulus(0, 1, 2, 0, 0);
        applyStimulus(0, 1, 2, 0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 1, 2, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 2, 1, i);
        checkVal("req036_drops", drops, 0);
        checkVal("req036_pulses", pulses, 1);
        checkVal("req036_avg", lastAvg, 2);

        // randomized lines and frames
        for (int line = 0; line < 24; line++) begin
            int nb;
            int na;
            int sh;
            nb = $urandom_range(1, 4);
            sh = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            for (int b = 0; b < nb; b++) begin
                bit hsBlank;
                hsBlank = $urandom_range(0, 1);
                applyStimulus(!hsBlank, hsBlank, sh, $urandom_range(0, 1),
                              $urandom_range(0, 255));
            end
            na = $urandom_range(10, 300);
            for (int a = 0; a < na; a++)
                applyStimulus(1, 1, $urandom_range(0, 15), ($urandom_range(0, 3) != 0),
                              $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp2_block_avg.md
EXP2_BLOCK_AVG -- requirements
Module: exp2_block_avg

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: i_hs  input  1  high = line active; low = horizontal blanking.
REQ-004 SHALL have: i_vs  input  1  high = frame active; low = vertical blanking.
REQ-005 SHALL have: i_shift_bit  input  4  log2 of block width; 0..7 valid, 8..15 invalid.
REQ-006 SHALL have: i_valid  input  1  pixel qualifier for i_data.
REQ-007 SHALL have: i_data  input  8  pixel value.
REQ-008 SHALL have: o_interval  output  8  block width, 1<<shift_r, or 0 if shift_r>=8.
REQ-009 SHALL have: o_avg  output  8  block average, sum>>shift_r.
REQ-010 SHALL have: o_avg_valid  output  1  one-cycle pulse, o_avg updated.
REQ-011 SHALL have: o_drop  output  1  one-cycle pulse, partial block discarded at blanking.
REQ-012 SHALL have: o_cfg_err  output  1  level, shift_r>=8.

Function
REQ-013 Blanking = (!i_hs || !i_vs); active = i_hs && i_vs.
REQ-014 shift_r SHALL load i_shift_bit on every blanking cycle and SHALL hold during active; mid-line i_shift_bit changes have no effect until next blanking.
REQ-015 o_interval and o_cfg_err SHALL be combinational decodes of shift_r.
REQ-016 Internal state: cnt (7 bit, pixels accumulated in current block), acc (15 bit, running sum; max 128*255=32640 fits, no overflow).
REQ-017 Active, i_valid=1, cfg valid, cnt < o_interval-1: acc <= acc+i_data, cnt <= cnt+1.
REQ-018 Active, i_valid=1, cfg valid, cnt == o_interval-1 (block complete): o_avg <= (acc+i_data)>>shift_r (low 8 bits), o_avg_valid <= 1, acc <= 0, cnt <= 0.
REQ-019 Latency: o_avg_valid SHALL assert exactly 1 cycle after the clock edge sampling the last pixel of a block.
REQ-020 shift_r=0: every valid pixel SHALL produce o_avg=i_data with o_avg_valid next cycle.
REQ-021 Active, i_valid=0: cnt, acc, o_avg hold; o_avg_valid <= 0.
REQ-022 o_avg SHALL hold its last value between pulses.
REQ-023 First blanking cycle with cnt != 0 (previous cycle active): acc <= 0, cnt <= 0, o_drop <= 1 for one cycle; no o_avg_valid for the partial block.
REQ-024 Blanking with cnt == 0: no o_drop; acc, cnt stay 0; i_valid ignored.
REQ-025 Blanking SHALL take priority over i_valid on the same cycle: pixel not accumulated, block-complete not taken.
REQ-026 o_cfg_err=1: pixels SHALL be ignored, acc/cnt held at 0, o_avg_valid and o_drop stay 0.
REQ-027 o_avg_valid and o_drop SHALL never both be 1.

Reset
REQ-028 rst_n=0 SHALL asynchronously force shift_r=0, cnt=0, acc=0, o_avg=0, o_avg_valid=0, o_drop=0; hence o_interval=1, o_cfg_err=0.
REQ-029 Reset assertion mid-block SHALL discard the partial block without an o_drop pulse.
REQ-030 After rst_n deassert, operation SHALL start on the next rising clk edge; partial state never survives reset.

Verification
REQ-031 Blanking with i_shift_bit=2, then active, i_data=10,20,30,40 on 4 consecutive valid cycles -> o_interval=4; one o_avg_valid pulse 1 cycle after 4th pixel, o_avg=25.
REQ-032 i_shift_bit=7, 128 valid pixels of 255 with random i_valid gaps -> single pulse, o_avg=255, no overflow; gaps do not shift block boundary.
REQ-033 i_shift_bit=3, 5 valid pixels then i_hs low -> o_drop pulses once in first blanking cycle, no o_avg_valid; next line's first block of 8 averages correctly.
REQ-034 i_shift_bit=9 during blanking, active pixels -> o_cfg_err=1, o_interval=0, no o_avg_valid/o_drop; change to 0 in next blanking -> per-pixel passthrough, o_cfg_err=0.
REQ-035 i_shift_bit changed 2->5 mid-line -> blocks of 4 continue until blanking; next line blocks of 32.
REQ-036 rst_n pulsed low after 3 of 4 pixels -> all outputs 0 immediately, no o_drop; after release a full 4-pixel block produces correct o_avg.
